// File: rtl/gray_step_tracker.sv
// Samples a 3-bit Gray counter, tracks signed step position and direction, flags multi-bit jumps as sticky err.
// Optional macro GRAY_SYNC_EN inserts a 2-flop input synchronizer (latency 3 instead of 1).
module gray_step_tracker #(
  parameter int POS_W = 8
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic [2:0]              G,
  input  logic                    clr,
  output logic [2:0]              bin,
  output logic signed [POS_W-1:0] pos,
  output logic                    step,
  output logic                    dir,
  output logic                    err,
  output logic                    valid
);

  typedef enum logic [1:0] {INIT, TRACK, FAULT} state_t;

  localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);

  state_t     state;
  logic [2:0] s;
  logic [2:0] b;
  logic [2:0] d;

`ifdef GRAY_SYNC_EN
  logic [2:0] sync_a;
  logic [2:0] sync_b;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sync_a <= 3'b000;
      sync_b <= 3'b000;
    end else begin
      sync_a <= G;
      sync_b <= sync_a;
    end
  end

  assign s = sync_b;
`else
  assign s = G;
`endif

  assign b = {s[2], s[2] ^ s[1], s[2] ^ s[1] ^ s[0]};
  // bin always equals the last accepted sample, so it doubles as the reference
  assign d = b - bin;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state <= INIT;
      bin   <= 3'b000;
      pos   <= '0;
      step  <= 1'b0;
      dir   <= 1'b0;
      err   <= 1'b0;
      valid <= 1'b0;
    end else if (clr) begin
      state <= INIT;
      pos   <= '0;
      step  <= 1'b0;
      dir   <= 1'b0;
      err   <= 1'b0;
      valid <= 1'b0;
    end else begin
      step <= 1'b0;
      case (state)
        INIT: begin
          bin   <= b;
          valid <= 1'b1;
          state <= TRACK;
        end
        TRACK: begin
          if (d == 3'd1) begin
            pos  <= pos + POS_ONE;
            dir  <= 1'b0;
            step <= 1'b1;
            bin  <= b;
          end else if (d == 3'd7) begin
            pos  <= pos - POS_ONE;
            dir  <= 1'b1;
            step <= 1'b1;
            bin  <= b;
          end else if (d != 3'd0) begin
            err   <= 1'b1;
            valid <= 1'b0;
            state <= FAULT;
          end
        end
        FAULT: begin
          err <= 1'b1;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule
